// File: rtl/val2_pkg.sv
// ============================================================================
//  val2_pkg : shared shift-type codes and operand-2 mode decode
//  Rev 1.0
// ============================================================================
`default_nettype none

package val2_pkg;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    typedef enum logic [1:0] {
        MODE_MEM = 2'd0,
        MODE_IMM = 2'd1,
        MODE_REG = 2'd2,
        MODE_ISH = 2'd3
    } mode_e;

    // Memory offsets win over the I bit, which wins over register shifts.
    function automatic mode_e decode_mode(
        input logic is_mem,
        input logic is_imm,
        input logic reg_shift
    );
        if (is_mem) begin
            return MODE_MEM;
        end else if (is_imm) begin
            return MODE_IMM;
        end else if (reg_shift) begin
            return MODE_REG;
        end
        return MODE_ISH;
    endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shift_core.sv
// ============================================================================
//  barrel_shift_core : combinational LSL/LSR/ASR/ROR/RRX with carry-out
//  Rev 1.0
// ============================================================================
`default_nettype none

module barrel_shift_core
    import val2_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = $clog2(DATA_W) + 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        shift_type,
    input  logic [AMT_W-1:0]  amount,
    input  logic              rrx,
    input  logic              carry_in,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    // One extra bit on each shifter catches the last bit shifted out.
    logic [DATA_W:0]        w_lsl;
    logic [DATA_W:0]        w_lsr;
    logic signed [DATA_W:0] w_asr;
    logic [DATA_W-1:0]      w_ror;

    assign w_lsl = {1'b0, data} << amount;
    assign w_lsr = {data, 1'b0} >> amount;
    assign w_asr = $signed({data, 1'b0}) >>> amount;
    assign w_ror = DATA_W'({data, data} >> amount);

    always_comb begin
        result = data;
        carry  = carry_in;
        if (rrx) begin
            result = {carry_in, data[DATA_W-1:1]};
            carry  = data[0];
        end else if (amount != '0) begin
            case (shift_type)
                SHIFT_LSL: begin
                    result = w_lsl[DATA_W-1:0];
                    carry  = w_lsl[DATA_W];
                end
                SHIFT_LSR: begin
                    result = w_lsr[DATA_W:1];
                    carry  = w_lsr[0];
                end
                SHIFT_ASR: begin
                    result = w_asr[DATA_W:1];
                    carry  = w_asr[0];
                end
                default: begin
                    result = w_ror;
                    carry  = w_ror[DATA_W-1];
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/val2_shift_pipe.sv
// ============================================================================
//  val2_shift_pipe : 2-stage operand-2 generator with valid/ready and flush
//  Rev 1.0
// ============================================================================
`default_nettype none

module val2_shift_pipe
    import val2_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AMT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val_rs,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val2,
    output logic              shifter_carry
);

    localparam logic [31:0]      c_dw       = 32'(DATA_W);
    localparam logic [31:0]      c_dw_mask  = 32'(DATA_W - 1);
    localparam logic [AMT_W-1:0] c_amt_full = AMT_W'(DATA_W);

    mode_e             w_mode;
    logic [DATA_W-1:0] w_d_data;
    logic [1:0]        w_d_type;
    logic [AMT_W-1:0]  w_d_amt;
    logic              w_d_rrx;
    logic [31:0]       w_raw_amt;
    logic [31:0]       w_ror_mod;
    logic              w_sat;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [1:0]        r_s1_type;
    logic [AMT_W-1:0]  r_s1_amt;
    logic              r_s1_rrx;
    logic              r_s1_cin;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_val2;
    logic              r_carry;

    logic              w_s1_adv;
    logic              w_in_ready;
    logic [DATA_W-1:0] w_core_result;
    logic              w_core_carry;
    logic              w_unused_rs;

    assign w_unused_rs = &{1'b0, val_rs[DATA_W-1:8]};

    assign w_s1_adv   = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_adv;

    // Every mode is folded into (data, type, amount, rrx) for the shared shifter.
    always_comb begin
        w_mode    = decode_mode(mem_read || mem_write, imm, shift_operand[4]);
        w_d_data  = val_rm;
        w_d_type  = shift_operand[6:5];
        w_d_amt   = '0;
        w_d_rrx   = 1'b0;
        w_raw_amt = '0;
        w_sat     = 1'b0;
        w_ror_mod = '0;
        case (w_mode)
            MODE_MEM: begin
                w_d_data = DATA_W'(shift_operand);
                w_d_type = SHIFT_LSL;
            end
            MODE_IMM: begin
                w_d_data = DATA_W'(shift_operand[7:0]);
                w_d_type = SHIFT_ROR;
                w_d_amt  = AMT_W'({shift_operand[11:8], 1'b0});
            end
            MODE_REG: begin
                w_raw_amt = 32'(val_rs[7:0]);
                w_sat     = (w_raw_amt != '0);
            end
            default: begin
                w_raw_amt = 32'(shift_operand[11:7]);
                if (w_raw_amt != '0) begin
                    w_sat = 1'b1;
                end else if (shift_operand[6:5] == SHIFT_ROR) begin
                    w_d_rrx = 1'b1;
                end else if (shift_operand[6:5] != SHIFT_LSL) begin
                    w_d_amt = c_amt_full;
                end
            end
        endcase

        // Over-range amounts: zeroing the data makes a full-width shift yield 0/carry 0.
        if (w_sat) begin
            w_ror_mod = w_raw_amt & c_dw_mask;
            case (w_d_type)
                SHIFT_LSL, SHIFT_LSR: begin
                    if (w_raw_amt > c_dw) begin
                        w_d_data = '0;
                        w_d_amt  = c_amt_full;
                    end else begin
                        w_d_amt = AMT_W'(w_raw_amt);
                    end
                end
                SHIFT_ASR: begin
                    w_d_amt = (w_raw_amt >= c_dw) ? c_amt_full : AMT_W'(w_raw_amt);
                end
                default: begin
                    w_d_amt = (w_ror_mod == '0) ? c_amt_full : AMT_W'(w_ror_mod);
                end
            endcase
        end
    end

    barrel_shift_core #(
        .DATA_W (DATA_W),
        .AMT_W  (AMT_W)
    ) u_core (
        .data       (r_s1_data),
        .shift_type (r_s1_type),
        .amount     (r_s1_amt),
        .rrx        (r_s1_rrx),
        .carry_in   (r_s1_cin),
        .result     (w_core_result),
        .carry      (w_core_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_type   <= SHIFT_LSL;
            r_s1_amt    <= '0;
            r_s1_rrx    <= 1'b0;
            r_s1_cin    <= 1'b0;
            r_out_valid <= 1'b0;
            r_val2      <= '0;
            r_carry     <= 1'b0;
        end else if (flush) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_val2  <= w_core_result;
                    r_carry <= w_core_carry;
                end
            end
            if (w_in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data <= w_d_data;
                    r_s1_type <= w_d_type;
                    r_s1_amt  <= w_d_amt;
                    r_s1_rrx  <= w_d_rrx;
                    r_s1_cin  <= carry_in;
                end
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign val2          = r_val2;
    assign shifter_carry = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_val2_shift_pipe.sv
// ============================================================================
//  tb_val2_shift_pipe : directed + randomized checks against an arithmetic model
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_val2_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, imm, mem_read, mem_write;
    logic        carry_in, out_valid, out_ready, shifter_carry;
    logic [11:0] shift_operand;
    logic [31:0] val_rm, val_rs, val2;

    int n_checks = 0;
    int n_errors = 0;
    int n_recv   = 0;
    bit stop_rdy = 1'b0;

    typedef struct packed {
        logic [31:0] v;
        logic        c;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    val2_shift_pipe #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .shift_operand (shift_operand),
        .imm           (imm),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .val_rm        (val_rm),
        .val_rs        (val_rs),
        .carry_in      (carry_in),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .val2          (val2),
        .shifter_carry (shifter_carry)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Operand-2 rules written directly from the ARM shifter definition.
    function automatic exp_t model(input logic [11:0] op, input logic im, input logic mr,
                                   input logic mw, input logic [31:0] rm,
                                   input logic [31:0] rs, input logic ci);
        exp_t r;
        int   a;
        int   m;
        int   rot;
        r.v = rm;
        r.c = ci;
        if (mr || mw) begin
            r.v = {20'b0, op};
            r.c = ci;
        end else if (im) begin
            rot = 2 * int'(op[11:8]);
            if (rot == 0) begin
                r.v = {24'b0, op[7:0]};
                r.c = ci;
            end else begin
                r.v = ror32({24'b0, op[7:0]}, rot);
                r.c = r.v[31];
            end
        end else begin
            a = op[4] ? int'(rs[7:0]) : int'(op[11:7]);
            if (a == 0 && op[4]) begin
                r.v = rm;
                r.c = ci;
            end else if (a == 0) begin
                case (op[6:5])
                    2'd0: begin r.v = rm; r.c = ci; end
                    2'd1: begin r.v = 32'd0; r.c = rm[31]; end
                    2'd2: begin r.v = {32{rm[31]}}; r.c = rm[31]; end
                    default: begin r.v = {ci, rm[31:1]}; r.c = rm[0]; end
                endcase
            end else begin
                case (op[6:5])
                    2'd0: begin
                        if (a < 32) begin r.v = rm << a; r.c = rm[32 - a]; end
                        else if (a == 32) begin r.v = 32'd0; r.c = rm[0]; end
                        else begin r.v = 32'd0; r.c = 1'b0; end
                    end
                    2'd1: begin
                        if (a < 32) begin r.v = rm >> a; r.c = rm[a - 1]; end
                        else if (a == 32) begin r.v = 32'd0; r.c = rm[31]; end
                        else begin r.v = 32'd0; r.c = 1'b0; end
                    end
                    2'd2: begin
                        if (a < 32) begin r.v = 32'($signed(rm) >>> a); r.c = rm[a - 1]; end
                        else begin r.v = {32{rm[31]}}; r.c = rm[31]; end
                    end
                    default: begin
                        m = a % 32;
                        if (m == 0) begin r.v = rm; r.c = rm[31]; end
                        else begin r.v = ror32(rm, m); r.c = rm[m - 1]; end
                    end
                endcase
            end
        end
        return r;
    endfunction

    // Scoreboard: expected results queued at acceptance, compared while presented.
    always @(negedge clk) begin
        exp_t dummy;
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    chk("sb_val2", val2, exp_q[0].v);
                    chk("sb_carry", shifter_carry, exp_q[0].c);
                    if (out_ready) begin
                        dummy = exp_q.pop_front();
                        n_recv++;
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(shift_operand, imm, mem_read, mem_write,
                                      val_rm, val_rs, carry_in));
        end
    end

    task automatic drive(input logic [11:0] op, input logic im, input logic mr, input logic mw,
                         input logic [31:0] rm, input logic [31:0] rs, input logic ci);
        shift_operand = op;
        imm           = im;
        mem_read      = mr;
        mem_write     = mw;
        val_rm        = rm;
        val_rs        = rs;
        carry_in      = ci;
    endtask

    task automatic send(input logic [11:0] op, input logic im, input logic mr, input logic mw,
                        input logic [31:0] rm, input logic [31:0] rs, input logic ci);
        logic acc;
        acc = 1'b0;
        drive(op, im, mr, mw, rm, rs, ci);
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [11:0] op;
        logic        im, mr, mw;
        logic [31:0] rs;
        logic [7:0]  edges [8];
        int          sel;
        edges = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd63, 8'd64, 8'd255};
        sel = $urandom_range(0, 3);
        op  = 12'($urandom);
        im  = 1'b0;
        mr  = 1'b0;
        mw  = 1'b0;
        rs  = $urandom;
        if ($urandom_range(0, 1) == 1) rs[7:0] = edges[$urandom_range(0, 7)];
        case (sel)
            0: begin {mr, mw} = 2'($urandom_range(1, 3)); im = 1'($urandom); end
            1: im = 1'b1;
            2: op[4] = 1'b1;
            default: begin
                op[4] = 1'b0;
                if ($urandom_range(0, 2) == 0) op[11:7] = 5'd0;
            end
        endcase
        send(op, im, mr, mw, $urandom, rs, 1'($urandom));
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int k = 0; k < max_cycles && exp_q.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single op into an empty pipe: checks 2-cycle latency and the spec's value.
    task automatic run_one(input string tag, input logic [11:0] op, input logic im,
                           input logic mr, input logic mw, input logic [31:0] rm,
                           input logic [31:0] rs, input logic ci,
                           input logic [31:0] ev, input logic ec);
        drive(op, im, mr, mw, rm, rs, ci);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_val2"}, val2, ev);
        chk({tag, "_carry"}, shifter_carry, ec);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(12'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_val2", val2, 0);
        chk("rst_carry", shifter_carry, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("imm_rot8",  12'h4FF, 1, 0, 0, 32'h0, 32'h0, 0, 32'hFF000000, 1);
        run_one("imm_rot0",  12'h0FF, 1, 0, 0, 32'h0, 32'h0, 1, 32'h000000FF, 1);
        run_one("reg_lsl32", 12'h010, 0, 0, 0, 32'h1, 32'd32, 0, 32'h0, 1);
        run_one("reg_lsl33", 12'h010, 0, 0, 0, 32'h1, 32'd33, 1, 32'h0, 0);
        run_one("reg_lsl0",  12'h010, 0, 0, 0, 32'h1, 32'd0, 0, 32'h1, 0);
        run_one("ish_asr0",  12'h040, 0, 0, 0, 32'h80000000, 32'h0, 0, 32'hFFFFFFFF, 1);
        run_one("ish_rrx",   12'h060, 0, 0, 0, 32'h3, 32'h0, 1, 32'h80000001, 1);
        run_one("mem_imm",   12'hABC, 1, 1, 0, 32'h12345678, 32'h0, 1, 32'h00000ABC, 1);
        run_one("mem_str",   12'hABC, 0, 0, 1, 32'h12345678, 32'h0, 0, 32'h00000ABC, 0);
        run_one("ish_lsr0",  12'h020, 0, 0, 0, 32'h80000001, 32'h0, 0, 32'h0, 1);
        run_one("reg_ror32", 12'h070, 0, 0, 0, 32'h7FFFFFFF, 32'h120, 1, 32'h7FFFFFFF, 0);

        // Four back-to-back ops with the consumer stalled for three cycles mid-stream.
        base = n_recv;
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand();
            end
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain(50);
        chk("stall_count", 64'(n_recv - base), 4);
        chk("stall_drain", 64'(exp_q.size()), 0);

        // Random stream with random consumer back-pressure.
        base = n_recv;
        stop_rdy = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) send_rand();
                stop_rdy = 1'b1;
            end
            begin
                while (!stop_rdy) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain(100);
        chk("rand_count", 64'(n_recv - base), 150);
        chk("rand_drain", 64'(exp_q.size()), 0);

        // Flush with two ops in flight and a third offered in the flush cycle.
        out_ready = 1'b0;
        send(12'h4FF, 1, 0, 0, 32'h0, 32'h0, 0);
        send(12'h010, 0, 0, 0, 32'h1, 32'd4, 0);
        chk("pre_flush_valid", out_valid, 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        drive(12'h0FF, 1, 0, 0, 32'h0, 32'h0, 1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("flush_dropped", out_valid, 0);

        // Asynchronous reset while a result is stalled at the output.
        out_ready = 1'b0;
        send(12'h060, 0, 0, 0, 32'h3, 32'h0, 1);
        for (int k = 0; k < 5 && !out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("stall_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_val2", val2, 0);
        chk("arst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run_one("post_rst", 12'h200, 0, 0, 0, 32'h000000F1, 32'h0, 0, 32'h00000F10, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
